// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and owner tags for the I/D bus arbiter.
// Imported by the arbiter top and its starvation counter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [3:0] HPROT_INST = 4'b0000;
    localparam logic [3:0] HPROT_DATA = 4'b0001;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/ahb_starve_counter.sv
// Counts consecutive cycles a pending fetch loses arbitration and
// raises force_o once the limit is reached so fetch wins once.
module ahb_starve_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic gnt_i,
    output logic force_o
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (gnt_i || !req_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (STARVE_LIMIT != 0) && (cnt_q == LIM);

endmodule

// File: rtl/ahb_imem_dmem_arbiter.sv
// Shares one AHB-Lite master port between fetch (I) and data (D),
// overlapping each address phase with the previous data phase.
import ahb_pkg::*;

module ahb_imem_dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_req,
    input  logic [31:0] I_addr,
    output logic        I_gnt,
    output logic        I_done,
    output logic [31:0] I_rdata,
    output logic        I_err,
    input  logic        D_req,
    input  logic [31:0] D_addr,
    input  logic        D_write,
    input  logic [2:0]  D_size,
    input  logic [31:0] D_wdata,
    output logic        D_gnt,
    output logic        D_done,
    output logic [31:0] D_rdata,
    output logic        D_err,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [1:0]  HTRANS,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    logic   force_i;
    logic   win_i;
    logic   win_d;
    logic   err1;
    logic   act;

    logic   dp_valid_q, dp_valid_d;
    owner_e dp_owner_q, dp_owner_d;
    logic   dp_write_q, dp_write_d;
    logic [31:0] dp_wdata_q, dp_wdata_d;

    ahb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) u_starve (
        .clk_i  (CLK),
        .rst_i  (RST),
        .req_i  (I_req),
        .gnt_i  (I_gnt),
        .force_o(force_i)
    );

    // First ERROR cycle: the slave expects IDLE on the address bus
    assign err1  = dp_valid_q && !HREADY && HRESP;
    assign win_i = I_req && (!D_req || force_i);
    assign win_d = D_req && !win_i;
    assign act   = (win_i || win_d) && !err1 && !RST;

    always_comb begin
        HTRANS = HTRANS_IDLE;
        HADDR  = '0;
        HWRITE = 1'b0;
        HSIZE  = '0;
        HPROT  = '0;
        if (act) begin
            HTRANS = HTRANS_NONSEQ;
            if (win_i) begin
                HADDR = I_addr;
                HSIZE = HSIZE_WORD;
                HPROT = HPROT_INST;
            end else begin
                HADDR  = D_addr;
                HWRITE = D_write;
                HSIZE  = D_size;
                HPROT  = HPROT_DATA;
            end
        end
    end

    assign I_gnt = act && win_i && HREADY;
    assign D_gnt = act && win_d && HREADY;

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_owner_d = dp_owner_q;
        dp_write_d = dp_write_q;
        dp_wdata_d = dp_wdata_q;
        if (HREADY) begin
            dp_valid_d = I_gnt || D_gnt;
            dp_owner_d = win_i ? OWNER_I : OWNER_D;
            dp_write_d = HWRITE;
            if (D_gnt && D_write) begin
                dp_wdata_d = D_wdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dp_valid_q <= 1'b0;
            dp_owner_q <= OWNER_D;
            dp_write_q <= 1'b0;
            dp_wdata_q <= '0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_owner_q <= dp_owner_d;
            dp_write_q <= dp_write_d;
            dp_wdata_q <= dp_wdata_d;
        end
    end

    assign HWDATA = (dp_valid_q && dp_write_q && !RST) ? dp_wdata_q : '0;

    assign I_done = dp_valid_q && (dp_owner_q == OWNER_I) && HREADY && !RST;
    assign D_done = dp_valid_q && (dp_owner_q == OWNER_D) && HREADY && !RST;

    assign I_rdata = HRDATA;
    assign D_rdata = HRDATA;
    assign I_err   = I_done && HRESP;
    assign D_err   = D_done && HRESP;

    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_imem_dmem_arbiter.sv
// Directed cycle-by-cycle vectors for the I/D AHB arbiter, plus
// hand sequences for starvation rotation and reset of the counter.
module tb_ahb_imem_dmem_arbiter;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        dwr;
        logic [2:0]  dsz;
        logic [31:0] dwd;
        logic [31:0] hrd;
        logic        hrdy;
        logic        hrsp;
    } in_t;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        logic        ig;
        logic        dg;
        logic        id;
        logic        dd;
        logic        ierr;
        logic        derr;
    } exp_t;

    typedef struct {
        string nm;
        in_t   i;
        exp_t  e;
    } vec_t;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SW = 3'b010;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_req, D_req, D_write, HREADY, HRESP;
    logic [31:0] I_addr, D_addr, D_wdata, HRDATA;
    logic [2:0]  D_size;
    logic        I_gnt, I_done, I_err, D_gnt, D_done, D_err;
    logic [31:0] I_rdata, D_rdata, HADDR, HWDATA;
    logic        HWRITE, HMASTLOCK;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;
    logic [3:0]  HPROT;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t tbl[$];

    ahb_imem_dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .I_req(I_req), .I_addr(I_addr), .I_gnt(I_gnt),
        .I_done(I_done), .I_rdata(I_rdata), .I_err(I_err),
        .D_req(D_req), .D_addr(D_addr), .D_write(D_write),
        .D_size(D_size), .D_wdata(D_wdata), .D_gnt(D_gnt),
        .D_done(D_done), .D_rdata(D_rdata), .D_err(D_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input in_t v);
        RST     = v.rst;
        I_req   = v.ireq;
        I_addr  = v.iaddr;
        D_req   = v.dreq;
        D_addr  = v.daddr;
        D_write = v.dwr;
        D_size  = v.dsz;
        D_wdata = v.dwd;
        HRDATA  = v.hrd;
        HREADY  = v.hrdy;
        HRESP   = v.hrsp;
    endtask

    task automatic check(input vec_t v);
        exp_t e;
        logic ok;
        e  = v.e;
        ok = (HTRANS == e.trans) && (HADDR == e.addr) &&
             (HWRITE == e.wr) && (HSIZE == e.size) &&
             (HPROT == e.prot) && (HWDATA == e.wdata) &&
             (I_gnt == e.ig) && (D_gnt == e.dg) &&
             (I_done == e.id) && (D_done == e.dd) &&
             (I_err == e.ierr) && (D_err == e.derr) &&
             (HBURST == 3'b000) && (HMASTLOCK == 1'b0) &&
             (!e.id || I_rdata == v.i.hrd) &&
             (!e.dd || D_rdata == v.i.hrd);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got trans=%b addr=%h wr=%b size=%0d prot=%b wdata=%h ig=%b dg=%b id=%b dd=%b ierr=%b derr=%b ird=%h drd=%h; want trans=%b addr=%h wr=%b size=%0d prot=%b wdata=%h ig=%b dg=%b id=%b dd=%b ierr=%b derr=%b rd=%h",
                v.nm, HTRANS, HADDR, HWRITE, HSIZE, HPROT, HWDATA,
                I_gnt, D_gnt, I_done, D_done, I_err, D_err,
                I_rdata, D_rdata,
                e.trans, e.addr, e.wr, e.size, e.prot, e.wdata,
                e.ig, e.dg, e.id, e.dd, e.ierr, e.derr, v.i.hrd);
        end
    endtask

    // Both sides requesting; only the grant pair is checked
    task automatic both(input logic rst, input logic [1:0] want,
                        input string nm);
        RST = rst; I_req = 1'b1; I_addr = 32'h40;
        D_req = 1'b1; D_addr = 32'h50; D_write = 1'b0;
        D_size = SW; D_wdata = '0; HRDATA = '0;
        HREADY = 1'b1; HRESP = 1'b0;
        @(negedge CLK);
        n_vec++;
        if ({I_gnt, D_gnt} != want) begin
            n_fail++;
            $display("FAIL %s: got {ig,dg}=%b want %b",
                     nm, {I_gnt, D_gnt}, want);
        end
        @(posedge CLK); #1;
    endtask

    function automatic vec_t mk(string nm, in_t i, exp_t e);
        vec_t v;
        v.nm = nm; v.i = i; v.e = e;
        return v;
    endfunction

    initial begin
        tbl.push_back(mk("reset",
            '{1,0,0,1,32'h10000004,0,SW,0,0,1,0},
            '{ID,0,0,0,0,0, 0,0,0,0,0,0}));
        tbl.push_back(mk("dload_addr",
            '{0,0,0,1,32'h10000004,0,SW,0,0,1,0},
            '{NS,32'h10000004,0,SW,4'b0001,0, 0,1,0,0,0,0}));
        tbl.push_back(mk("dload_data",
            '{0,0,0,0,0,0,0,0,32'hDEADBEEF,1,0},
            '{ID,0,0,0,0,0, 0,0,0,1,0,0}));
        tbl.push_back(mk("dstore_addr",
            '{0,0,0,1,32'h20000001,1,SB,32'hA5,0,1,0},
            '{NS,32'h20000001,1,SB,4'b0001,0, 0,1,0,0,0,0}));
        tbl.push_back(mk("dstore_wait1",
            '{0,1,32'h100,0,0,0,0,0,0,0,0},
            '{NS,32'h100,0,SW,0,32'hA5, 0,0,0,0,0,0}));
        tbl.push_back(mk("dstore_wait2",
            '{0,1,32'h100,0,0,0,0,0,0,0,0},
            '{NS,32'h100,0,SW,0,32'hA5, 0,0,0,0,0,0}));
        tbl.push_back(mk("dstore_done",
            '{0,1,32'h100,0,0,0,0,0,0,1,0},
            '{NS,32'h100,0,SW,0,32'hA5, 1,0,0,1,0,0}));
        tbl.push_back(mk("fetch_b2b",
            '{0,1,32'h104,0,0,0,0,0,32'h11111111,1,0},
            '{NS,32'h104,0,SW,0,0, 1,0,1,0,0,0}));
        tbl.push_back(mk("err_cycle1",
            '{0,1,32'h108,0,0,0,0,0,0,0,1},
            '{ID,0,0,0,0,0, 0,0,0,0,0,0}));
        tbl.push_back(mk("err_cycle2",
            '{0,1,32'h108,0,0,0,0,0,0,1,1},
            '{NS,32'h108,0,SW,0,0, 1,0,1,0,1,0}));
        tbl.push_back(mk("fetch_0",
            '{0,1,32'h0,0,0,0,0,0,32'hA0,1,0},
            '{NS,32'h0,0,SW,0,0, 1,0,1,0,0,0}));
        tbl.push_back(mk("fetch_4",
            '{0,1,32'h4,0,0,0,0,0,32'hA1,1,0},
            '{NS,32'h4,0,SW,0,0, 1,0,1,0,0,0}));
        tbl.push_back(mk("fetch_8",
            '{0,1,32'h8,0,0,0,0,0,32'hA2,1,0},
            '{NS,32'h8,0,SW,0,0, 1,0,1,0,0,0}));
        tbl.push_back(mk("fetch_drain",
            '{0,0,0,0,0,0,0,0,32'hA3,1,0},
            '{ID,0,0,0,0,0, 0,0,1,0,0,0}));
        tbl.push_back(mk("rstmid_addr",
            '{0,0,0,1,32'h30000000,0,SW,0,0,1,0},
            '{NS,32'h30000000,0,SW,4'b0001,0, 0,1,0,0,0,0}));
        tbl.push_back(mk("rstmid_rst",
            '{1,0,0,0,0,0,0,0,32'h55,1,0},
            '{ID,0,0,0,0,0, 0,0,0,0,0,0}));
        tbl.push_back(mk("rstmid_after",
            '{0,0,0,0,0,0,0,0,32'h55,1,0},
            '{ID,0,0,0,0,0, 0,0,0,0,0,0}));

        drive(tbl[0].i);
        @(posedge CLK); #1;
        foreach (tbl[k]) begin
            drive(tbl[k].i);
            @(negedge CLK);
            check(tbl[k]);
            @(posedge CLK); #1;
        end

        // Four D wins, then one forced I win, repeating
        for (int k = 0; k < 10; k++) begin
            both(1'b0, (k % 5 == 4) ? 2'b10 : 2'b01,
                 $sformatf("starve_%0d", k));
        end

        // Reset must clear a partially built-up starvation count
        for (int k = 0; k < 3; k++) begin
            both(1'b0, 2'b01, $sformatf("prerst_%0d", k));
        end
        both(1'b1, 2'b00, "rst_both");
        for (int k = 0; k < 5; k++) begin
            both(1'b0, (k == 4) ? 2'b10 : 2'b01,
                 $sformatf("postrst_%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_imem_dmem_arbiter.md
Name: ahb_imem_dmem_arbiter

Overview:
- Shares one AHB-Lite master port between the instruction-fetch requester (I) and the memory-stage data requester (D).
- Drives the address phase from the winning request and tracks the outstanding data phase, so an address phase can overlap the previous data phase.
- Returns read data, completion and error to the owner of each transfer.
- Sits between the fetch and memory pipeline stages and the single system bus; inserts HTRANS IDLE during the first error cycle.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles an ungranted I request may lose to D before I is forced to win once. 0 = strict D priority.
- CNT_W, 4: width of the starvation counter. Must satisfy STARVE_LIMIT < 2**CNT_W.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- I_req  in  1  fetch request; held with I_addr until I_gnt
- I_addr  in  32  fetch address (word access only)
- I_gnt  out  1  fetch address phase accepted this cycle
- I_done  out  1  fetch data phase completed this cycle
- I_rdata  out  32  fetch read data, valid when I_done
- I_err  out  1  fetch error, valid when I_done
- D_req  in  1  data request; held stable until D_gnt
- D_addr  in  32  data address
- D_write  in  1  1 = store
- D_size  in  3  HSIZE code: byte, halfword or word
- D_wdata  in  32  store data, sampled at D_gnt
- D_gnt, D_done, D_rdata, D_err  out  1/1/32/1  same meaning as the I_ outputs, for the D side
- HADDR  out  32  AHB address
- HWRITE  out  1  AHB write
- HSIZE  out  3  AHB size
- HBURST  out  3  AHB burst, always SINGLE
- HTRANS  out  2  AHB transfer type, IDLE or NONSEQ only
- HMASTLOCK  out  1  always 0
- HPROT  out  4  I: 4'b0000, D: 4'b0001
- HWDATA  out  32  AHB write data, driven in the data phase
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB response, 1 = ERROR

Behaviour:
- Reset, synchronous while RST=1:
  - dp_valid=0, dp_owner=D, dp_wdata=0, starve_cnt=0.
  - Outputs forced to: HTRANS=IDLE, all gnt and done = 0, HADDR=0, HWDATA=0.
- Arbitration is combinational in the same cycle, no added latency.
  - win_I = I_req && (!D_req || (STARVE_LIMIT!=0 && starve_cnt==STARVE_LIMIT)).
  - win_D = D_req && !win_I.
- Address phase:
  - If win_I or win_D and !err1, drive HTRANS=NONSEQ with the winner's address, HWRITE, HSIZE and HPROT.
  - Fetch always uses HWRITE=0 and HSIZE=word.
  - Otherwise drive HTRANS=IDLE and HADDR/HWRITE/HSIZE = 0.
- Grant: X_gnt = win_X && HREADY && !err1 && !RST. Requester holds its request and address until granted.
- err1 = dp_valid && !HREADY && HRESP, the first ERROR cycle. During err1, HTRANS=IDLE and no grant is issued.
- Data-phase registers update only when HREADY=1:
  - dp_valid <= any gnt.
  - dp_owner <= winner.
  - dp_write <= HWRITE.
  - dp_wdata <= D_wdata on a D write grant.
- HWDATA = dp_wdata whenever dp_valid && dp_write, else 0.
- Completion: X_done = dp_valid && dp_owner==X && HREADY. X_rdata = HRDATA and X_err = HRESP in that cycle; the other side's done is 0.
- Wait states: HREADY=0 holds the data phase and suppresses grants. The address outputs stay driven and stable.
- Starvation counter:
  - starve_cnt <= 0 when I_gnt or !I_req.
  - Otherwise saturating increment at STARVE_LIMIT.
  - Increments only on cycles where I_req && !I_gnt.
- Back-to-back: a new grant and the completion of the previous transfer happen in the same HREADY=1 cycle. The owner changes cleanly, giving one transfer per cycle at zero wait.
- Reset mid-transfer: the outstanding data phase is dropped and no done is reported. The bus slave is reset by the same RST.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_BYTE/HALF/WORD.
  - HPROT_INST=4'b0000, HPROT_DATA=4'b0001.
  - OWNER_I/OWNER_D encoding.
- One sub-module, ahb_starve_counter: the saturating counter plus the force-I compare output.

Test Plan:
- Single D load:
  - Stimulus: D_req, D_addr=0x1000_0004, size=word, HREADY=1.
  - Response: HTRANS=NONSEQ and D_gnt in cycle 0; D_done with D_rdata=HRDATA=0xDEADBEEF in cycle 1.
- Simultaneous requests, STARVE_LIMIT=4:
  - Stimulus: I_req and D_req held for 10 cycles.
  - Response: D granted 4 consecutive cycles, I granted on the 5th, then the pattern repeats; no cycle has both gnts.
- D store with wait states:
  - Stimulus: D_wdata=0x0000_00A5, size=byte, HREADY low 2 cycles in the data phase.
  - Response: HWDATA=0xA5 held for all 3 data cycles; D_done only on the HREADY=1 cycle; no new grant while HREADY=0.
- Error response:
  - Stimulus: slave gives HRESP=1/HREADY=0, then HRESP=1/HREADY=1, while I_req is pending.
  - Response: HTRANS=IDLE and no I_gnt in the first cycle; I_done=1, I_err=1 in the second; I granted no earlier than the second cycle.
- Pipelined fetch stream:
  - Stimulus: I_req continuous, addrs 0x0, 0x4, 0x8, HREADY=1, no D_req.
  - Response: one grant per cycle; I_done with matching data one cycle after each grant.
- Reset mid data phase:
  - Stimulus: RST=1 for one cycle during an outstanding D load.
  - Response: no D_done afterwards; HTRANS=IDLE and starve_cnt=0 in the cycle after reset.
